spi_target_regfile: RTL

SPI target that answers an external SPI initiator with the same pin set as the SoC's SPI master (SS, SCK, MOSI, MISO). It runs in mode 0 (CPOL=0, CPHA=0), MSB first, with 8-bit frames, and exposes a 16 x 8-bit register file. The SPI side can read and write the register file; the core can read all entries and preload values. The block sits behind the pad ring, next to the SoC peripherals. All SPI pins are oversampled in the system clock domain.

---
 rtl/spi_target_regfile.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target (MSB first, 8-bit frames) fronting a 16x8 register file with core preload/readback.
// Pin edges act SYNC_STAGES+1 clk after they occur; no backpressure, the initiator paces every transfer.
module spi_target_regfile #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_ss,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [3:0] reg_raddr,
  output logic [7:0] reg_rdata,
  input  logic       reg_we,
  input  logic [3:0] reg_waddr,
  input  logic [7:0] reg_wdata,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_t;

  logic [SYNC_STAGES-1:0] r_ss_sync, r_sck_sync, r_mosi_sync, r_sync_ok;
  logic                   r_ss_d, r_sck_d, r_armed;
  state_t                 r_state;
  logic [7:0]             r_regfile [16];
  logic [3:0]             r_addr;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift, r_tx_shift;
  logic                   r_busy, r_wr_valid;
  logic [3:0]             r_wr_addr;
  logic [7:0]             r_wr_data;

  logic       w_ss, w_sck, w_mosi;
  logic       w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
  logic [7:0] w_rx_byte;

  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // A frame already running when reset releases must not look like a fresh SS fall,
  // so falls only count once a real (non-reset) high level of SS has been seen.
  assign w_ss_fall  = r_armed & r_ss_d & ~w_ss;
  assign w_ss_rise  = ~r_ss_d & w_ss;
  assign w_sck_rise = ~r_sck_d & w_sck;
  assign w_sck_fall = r_sck_d & ~w_sck;
  assign w_rx_byte  = {r_rx_shift[6:0], w_mosi};

  assign spi_miso    = r_tx_shift[7];
  assign spi_miso_oe = r_busy;
  assign busy        = r_busy;
  assign wr_valid    = r_wr_valid;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign reg_rdata   = r_regfile[reg_raddr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ss_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_sync_ok   <= '0;
      r_ss_d      <= 1'b1;
      r_sck_d     <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_ss_sync   <= (r_ss_sync << 1) | SYNC_STAGES'(spi_ss);
      r_sck_sync  <= (r_sck_sync << 1) | SYNC_STAGES'(spi_clk);
      r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      r_sync_ok   <= (r_sync_ok << 1) | SYNC_STAGES'(1'b1);
      r_ss_d      <= w_ss;
      r_sck_d     <= w_sck;
      r_armed     <= r_armed | (r_sync_ok[SYNC_STAGES-1] & w_ss);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_regfile  <= '{default: '0};
      r_addr     <= '0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      // Core write first so a same-cycle SPI write to the same entry overrides it.
      if (reg_we) r_regfile[reg_waddr] <= reg_wdata;
      if (w_ss_rise) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (w_ss_fall) begin
            r_state    <= S_CMD;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_busy     <= 1'b1;
          end
          S_CMD: if (w_sck_rise) begin
            r_rx_shift <= w_rx_byte;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr  <= w_rx_byte[3:0];
              r_state <= w_rx_byte[7] ? S_RD : S_WR;
            end
          end
          S_WR: if (w_sck_rise) begin
            r_rx_shift <= w_rx_byte;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_regfile[r_addr] <= w_rx_byte;
              r_wr_valid        <= 1'b1;
              r_wr_addr         <= r_addr;
              r_wr_data         <= w_rx_byte;
              r_addr            <= r_addr + 4'd1;
            end
          end
          S_RD: begin
            if (w_sck_rise) begin
              r_rx_shift <= w_rx_byte;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
            end else if (w_sck_fall) begin
              // The fall that closes a byte loads the next one; the others shift.
              if (r_bit_cnt == 3'd0) begin
                r_tx_shift <= r_regfile[r_addr];
                r_addr     <= r_addr + 4'd1;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
